// File: rtl/m_mem_ctrl.sv
//==============================================================================
// Module      : m_mem_ctrl
// Description : M-stage data-memory access sequencer. Takes one load/store per
//               instruction, drives a req/ack data-memory bus with lane-shifted
//               write data and byte enables, stalls the pipeline while the
//               access is in flight and returns lane-extracted, sign/zero
//               extended load data.
//
// Parameters  : TIMEOUT_CYCLES - max REQ cycles without mem_ack before a bus
//                                error is reported (0 disables the timeout)
//               TIMER_W        - timeout counter width
//
// Ports       : clk, reset                      - clock, async active-high reset
//               cpu_req/we/type/sign/addr/wdata - access request from M stage
//               cpu_stall                       - freeze pipeline (combinational)
//               cpu_done/rdata/err              - completion pulse and results
//               mem_req/we/be/addr/wdata        - bus request side
//               mem_ack/rdata                   - bus response side
//
// Config      : MISALIGN_EXC_EN - when defined, misaligned half/word accesses
//                                 complete with cpu_err and no bus request;
//                                 when undefined, the low address bits are
//                                 forced to the natural alignment.
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module m_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMER_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_type,
    input  logic        cpu_sign,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Access size encoding on cpu_type
    localparam logic [1:0] C_TYPE_NONE = 2'b00;
    localparam logic [1:0] C_TYPE_WORD = 2'b01;
    localparam logic [1:0] C_TYPE_HALF = 2'b10;
    localparam logic [1:0] C_TYPE_BYTE = 2'b11;

    // Sequencer states
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_REQ  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;
    localparam logic [1:0] C_ST_ERR  = 2'd3;

    localparam bit               C_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMER_W-1:0] C_TIMER_LAST =
        TIMER_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [1:0]         state_q,  state_d;
    logic               we_q,     we_d;
    logic [1:0]         type_q,   type_d;
    logic               sign_q,   sign_d;
    logic [1:0]         off_q,    off_d;
    logic [3:0]         be_q,     be_d;
    logic [29:0]        addr_q,   addr_d;
    logic [31:0]        wdata_q,  wdata_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic [31:0]        rdata_q,  rdata_d;

    logic               w_accept;
    logic               w_misalign;
    logic [1:0]         w_off;
    logic [3:0]         w_be;
    logic [31:0]        w_lane_mask;
    logic [31:0]        w_wdata;
    logic [31:0]        w_lanes;
    logic [31:0]        w_load_data;

    //--------------------------------------------------------------------------
    // Request decode: effective byte offset, lane enables, shifted store data
    //--------------------------------------------------------------------------
    always_comb begin
        w_accept = cpu_req && (cpu_type != C_TYPE_NONE);

`ifdef MISALIGN_EXC_EN
        w_misalign = ((cpu_type == C_TYPE_HALF) && cpu_addr[0]) ||
                     ((cpu_type == C_TYPE_WORD) && (cpu_addr[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif

        // The offset is always rounded down to the access size; with the
        // exception enabled a misaligned access never reaches the bus anyway.
        case (cpu_type)
            C_TYPE_WORD: w_off = 2'b00;
            C_TYPE_HALF: w_off = {cpu_addr[1], 1'b0};
            default:     w_off = cpu_addr[1:0];
        endcase

        case (cpu_type)
            C_TYPE_WORD: w_be = 4'b1111;
            C_TYPE_HALF: w_be = w_off[1] ? 4'b1100 : 4'b0011;
            C_TYPE_BYTE: w_be = 4'b0001 << w_off;
            default:     w_be = 4'b0000;
        endcase

        w_lane_mask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
        w_wdata     = (cpu_wdata << {w_off, 3'b000}) & w_lane_mask;
    end

    //--------------------------------------------------------------------------
    // Load extraction from the registered lane offset
    //--------------------------------------------------------------------------
    always_comb begin
        w_lanes = mem_rdata >> {off_q, 3'b000};
        case (type_q)
            C_TYPE_HALF: w_load_data = {{16{sign_q & w_lanes[15]}}, w_lanes[15:0]};
            C_TYPE_BYTE: w_load_data = {{24{sign_q & w_lanes[7]}},  w_lanes[7:0]};
            default:     w_load_data = mem_rdata;
        endcase
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        type_d  = type_q;
        sign_d  = sign_q;
        off_d   = off_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        timer_d = timer_q;
        rdata_d = rdata_q;

        case (state_q)
            C_ST_IDLE: begin
                if (w_accept) begin
                    we_d    = cpu_we;
                    type_d  = cpu_type;
                    sign_d  = cpu_sign;
                    off_d   = w_off;
                    be_d    = w_be;
                    addr_d  = cpu_addr[31:2];
                    wdata_d = w_wdata;
                    timer_d = '0;
                    state_d = w_misalign ? C_ST_ERR : C_ST_REQ;
                end
            end

            C_ST_REQ: begin
                // An ack on the final timeout cycle still completes normally.
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = w_load_data;
                    end
                    state_d = C_ST_DONE;
                end else if (C_TIMEOUT_EN && (timer_q == C_TIMER_LAST)) begin
                    state_d = C_ST_ERR;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            // The instruction still presented during DONE/ERR is the one
            // that just completed, so both return to IDLE unconditionally.
            C_ST_DONE: state_d = C_ST_IDLE;
            C_ST_ERR:  state_d = C_ST_IDLE;
            default:   state_d = C_ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_ST_IDLE;
            we_q    <= 1'b0;
            type_q  <= C_TYPE_NONE;
            sign_q  <= 1'b0;
            off_q   <= 2'b00;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            timer_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            type_q  <= type_d;
            sign_q  <= sign_d;
            off_q   <= off_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            timer_q <= timer_d;
            rdata_q <= rdata_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs. cpu_stall is gated by reset so that an access abandoned by
    // reset releases the pipeline immediately even if cpu_req stays high.
    //--------------------------------------------------------------------------
    assign cpu_stall = !reset &&
                       (((state_q == C_ST_IDLE) && w_accept) || (state_q == C_ST_REQ));
    assign cpu_done  = (state_q == C_ST_DONE) || (state_q == C_ST_ERR);
    assign cpu_err   = (state_q == C_ST_ERR);
    assign cpu_rdata = rdata_q;

    assign mem_req   = (state_q == C_ST_REQ);
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_m_mem_ctrl.sv
//==============================================================================
// Module      : tb_m_mem_ctrl
// Description : Scoreboard testbench for m_mem_ctrl. A driver issues directed
//               and random accesses and pushes expected bus requests and
//               completions into queues; a monitor pops and compares them as
//               the DUT presents them. A bus responder acks after a chosen
//               delay (or never, to provoke a timeout).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_m_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_sign;
    logic [1:0]  cpu_type;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    m_mem_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .TIMER_W        (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_type  (cpu_type),
        .cpu_sign  (cpu_sign),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } bus_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } cmp_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata;
    } rsp_t;

    bus_t        bus_q[$];
    cmp_t        cmp_q[$];
    rsp_t        rsp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    //--------------------------------------------------------------------------
    // Reference model + driver for one access. delay >= TO means never ack.
    //--------------------------------------------------------------------------
    task automatic access(input logic we, input logic [1:0] typ, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int delay, input logic [31:0] rd);
        int          nbytes, la, off, n;
        logic        mis;
        logic [31:0] mask, v;
        bus_t        b;
        cmp_t        c;
        rsp_t        r;

        nbytes = (typ == 2'b01) ? 4 : (typ == 2'b10) ? 2 : 1;
        la     = int'(a[1:0]);
        mis    = 1'b0;
`ifdef MISALIGN_EXC_EN
        mis    = (la % nbytes) != 0;
`endif
        off    = la - (la % nbytes);
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);

        b.we    = we;
        b.be    = 4'(((1 << nbytes) - 1) << off);
        b.addr  = {a[31:2], 2'b00};
        b.wdata = (wd & mask) << (8 * off);
        b.len   = (delay < TO) ? delay + 1 : TO;

        v = (rd >> (8 * off)) & mask;
        if (sgn && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;

        c.err = mis || (delay >= TO);
        if (!c.err && !we) last_rdata = v;
        c.rdata = last_rdata;

        if (!mis) begin
            bus_q.push_back(b);
            r.delay = delay;
            r.rdata = rd;
            rsp_q.push_back(r);
        end
        cmp_q.push_back(c);

        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_type  = typ;
        cpu_sign  = sgn;
        cpu_addr  = a;
        cpu_wdata = wd;

        // Hold the instruction until the stall releases.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_stall && n < 40);
        chk("stall_release", {31'b0, cpu_stall}, 32'h0);

        @(posedge clk);
        #1;
        cpu_req  = 1'b0;
        cpu_type = 2'b00;
    endtask

    //--------------------------------------------------------------------------
    // Bus responder
    //--------------------------------------------------------------------------
    initial begin
        rsp_t r;
        bit   active;
        int   cnt;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        active    = 1'b0;
        cnt       = 0;
        r.delay   = 0;
        r.rdata   = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (!mem_req || reset) begin
                active = 1'b0;
            end else begin
                if (!active && rsp_q.size() > 0) begin
                    r      = rsp_q.pop_front();
                    active = 1'b1;
                    cnt    = r.delay;
                end
                if (active) begin
                    if (cnt == 0) begin
                        mem_ack   = 1'b1;
                        mem_rdata = r.rdata;
                        active    = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Monitor / scoreboard
    //--------------------------------------------------------------------------
    initial begin
        bus_t eb;
        cmp_t ec;
        bit   in_req, prev_ack;
        int   len;
        in_req   = 1'b0;
        prev_ack = 1'b0;
        len      = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_req   = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (prev_ack) chk("done_after_ack", {31'b0, cpu_done}, 32'h1);
                prev_ack = mem_req && mem_ack;

                if (mem_req) begin
                    if (!in_req) begin
                        if (bus_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_mem_req: got mem_req=1 expected 0 (t=%0t)", $time);
                        end else begin
                            eb = bus_q.pop_front();
                            chk("mem_we",    {31'b0, mem_we}, {31'b0, eb.we});
                            chk("mem_be",    {28'b0, mem_be}, {28'b0, eb.be});
                            chk("mem_addr",  mem_addr,  eb.addr);
                            chk("mem_wdata", mem_wdata, eb.wdata);
                            chk("stall_in_req", {31'b0, cpu_stall}, 32'h1);
                            in_req = 1'b1;
                            len    = 1;
                        end
                    end else begin
                        len++;
                    end
                end else if (in_req) begin
                    chk("req_length", len, eb.len);
                    in_req = 1'b0;
                end

                if (cpu_done) begin
                    if (cmp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got cpu_done=1 expected 0 (t=%0t)", $time);
                    end else begin
                        ec = cmp_q.pop_front();
                        chk("cpu_err",   {31'b0, cpu_err}, {31'b0, ec.err});
                        chk("cpu_rdata", cpu_rdata, ec.rdata);
                        chk("stall_at_done", {31'b0, cpu_stall}, 32'h0);
                    end
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    initial begin
        bus_t rb;
        rsp_t rr;

        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_type  = 2'b00;
        cpu_sign  = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
        chk("rst_done",  {31'b0, cpu_done},  32'h0);
        chk("rst_err",   {31'b0, cpu_err},   32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_req",   {31'b0, mem_req},   32'h0);
        chk("rst_we",    {31'b0, mem_we},    32'h0);
        chk("rst_be",    {28'b0, mem_be},    32'h0);
        chk("rst_addr",  mem_addr,  32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        // Directed cases
        access(1'b1, 2'b01, 1'b0, 32'h0000_0100, 32'h1234_5678, 2, 32'h0);
        access(1'b1, 2'b11, 1'b0, 32'h0000_0103, 32'hFFFF_FFAB, 0, 32'h0);
        access(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1111_BEEF, 1, 32'h0);
        access(1'b0, 2'b11, 1'b1, 32'h0000_0101, 32'h0, 0, 32'h0000_8000);
        access(1'b0, 2'b11, 1'b0, 32'h0000_0101, 32'h0, 1, 32'h0000_8000);
        access(1'b0, 2'b10, 1'b1, 32'h0000_0102, 32'h0, 2, 32'h8001_0000);
        access(1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0, 99, 32'h0);
        access(1'b0, 2'b01, 1'b0, 32'h0000_0204, 32'h0, TO - 1, 32'hA5A5_0F0F);
        access(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 1, 32'hCAFE_F00D);

        // Type 00 request is ignored: no stall, no bus activity
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_type = 2'b00;
        @(negedge clk);
        chk("none_stall", {31'b0, cpu_stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("none_req", {31'b0, mem_req}, 32'h0);
        cpu_req = 1'b0;

        // Reset while in REQ abandons the access
        rb.we = 1'b0; rb.be = 4'hF; rb.addr = 32'h300; rb.wdata = 32'h0; rb.len = 0;
        bus_q.push_back(rb);
        rr.delay = 1000; rr.rdata = 32'h0;
        rsp_q.push_back(rr);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_type = 2'b01;
        cpu_addr = 32'h300;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_req",   {31'b0, mem_req},   32'h0);
        chk("midrst_stall", {31'b0, cpu_stall}, 32'h0);
        chk("midrst_done",  {31'b0, cpu_done},  32'h0);
        @(posedge clk);
        #1;
        cpu_req  = 1'b0;
        cpu_type = 2'b00;
        bus_q.delete();
        rsp_q.delete();
        last_rdata = 32'h0;
        reset = 1'b0;
        chk("midrst_rdata", cpu_rdata, 32'h0);
        access(1'b0, 2'b01, 1'b0, 32'h0000_0400, 32'h0, 1, 32'h1357_9BDF);

        // Randomized accesses
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            access(1'($urandom_range(0, 1)),
                   2'($urandom_range(1, 3)),
                   1'($urandom_range(0, 1)),
                   $urandom, $urandom,
                   ($urandom_range(0, 7) == 0) ? 50 : int'($urandom_range(0, TO - 1)),
                   $urandom);
        end

        repeat (5) @(posedge clk);
        chk("cmp_q_empty", cmp_q.size(), 32'h0);
        chk("bus_q_empty", bus_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
